// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among byte sources,
// with optional per-source lock, burst cap and done-watchdog.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 1200000,
    parameter int TO_W      = 21
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   req_lock,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic               tx_ready,
    input  logic               tx_done,
    output logic               tx_load,
    output logic [7:0]         tx_data,
    output logic [N_REQ-1:0]   ack,
    output logic [IDX_W-1:0]   owner,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       burst_q, burst_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             found;
    logic             keep;
    logic             to_hit;

    assign keep   = lock_q && req[owner_q] && (burst_q < 8'(MAX_BURST));
    assign to_hit = (to_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        winner = rr_q;
        idx    = '0;
        found  = 1'b0;
        if (keep) begin
            winner = owner_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = rr_q + IDX_W'(k);
                if (!found && req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        data_d  = data_q;
        burst_d = burst_q;
        lock_d  = lock_q;
        err_d   = 1'b0;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (tx_ready && |req) begin
                    state_d = LOAD;
                    owner_d = winner;
                    data_d  = req_data[{winner, 3'b000} +: 8];
                    lock_d  = req_lock[winner];
                    burst_d = (winner == owner_q && lock_q)
                            ? burst_q + 8'd1 : 8'd1;
                end
            end
            LOAD: begin
                state_d = WAIT;
                to_d    = '0;
            end
            WAIT: begin
                // tx_done takes priority over a watchdog expiring this cycle
                if (tx_done) begin
                    state_d = IDLE;
                    if (!lock_q || burst_q >= 8'(MAX_BURST)) begin
                        rr_d   = owner_q + IDX_W'(1);
                        lock_d = 1'b0;
                    end
                end else if (to_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    rr_d    = owner_q + IDX_W'(1);
                    lock_d  = 1'b0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            data_q  <= '0;
            burst_q <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            burst_q <= burst_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign tx_load     = (state_q == LOAD);
    assign ack         = tx_load ? (N_REQ'(1) << owner_q) : '0;
    assign busy        = (state_q != IDLE);
    assign tx_data     = data_q;
    assign owner       = owner_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, corner sequences and
// randomized transactions against a transaction-level arbitration model.
module tb_uart_tx_arbiter;

    localparam int MB = 4;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [31:0] req_data;
    logic        tx_ready;
    logic        tx_done;
    logic        tx_load;
    logic [7:0]  tx_data;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(
        .N_REQ(4), .IDX_W(2), .MAX_BURST(MB), .TIMEOUT(TO), .TO_W(6)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_lock(req_lock),
        .req_data(req_data), .tx_ready(tx_ready), .tx_done(tx_done),
        .tx_load(tx_load), .tx_data(tx_data), .ack(ack), .owner(owner),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_rr, m_owner, m_burst;
    bit m_lock;

    typedef struct {
        logic [3:0] r;
        logic [3:0] lk;
        int         exp_owner;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[12];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset;
        m_rr = 0; m_owner = 0; m_burst = 0; m_lock = 0;
    endtask

    function automatic int model_pick(input logic [3:0] r);
        if (m_lock && r[m_owner] && m_burst < MB) return m_owner;
        for (int k = 0; k < 4; k++)
            if (r[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return -1;
    endfunction

    task automatic model_grant(input int w, input logic [3:0] lk);
        m_burst = (w == m_owner && m_lock) ? m_burst + 1 : 1;
        m_owner = w;
        m_lock  = lk[w];
    endtask

    task automatic model_done(input bit timed_out);
        if (timed_out || !m_lock || m_burst >= MB) begin
            m_rr   = (m_owner + 1) % 4;
            m_lock = 0;
        end
    endtask

    task automatic wait_load(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick;
            if (tx_load === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            checks++;
            errors++;
            $display("FAIL load_wait actual=none required=tx_load");
        end
    endtask

    task automatic check_grant(input string tag, input int w,
                               input logic [7:0] d);
        chk({tag, "_owner"}, 32'(owner), 32'(w));
        chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << w));
        chk({tag, "_data"}, 32'(tx_data), 32'(d));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic run_wait(input string tag, input int d, input bit to,
                            input logic [7:0] ed);
        int loads = 0;
        int cyc = 0;
        tick;
        chk({tag, "_ack_width"}, 32'(ack), 32'd0);
        chk({tag, "_held_data"}, 32'(tx_data), 32'(ed));
        if (to) begin
            for (int i = 0; i < TO + 10; i++) begin
                tick;
                cyc++;
                if (tx_load) loads++;
                if (timeout_err) break;
            end
            chk({tag, "_to_latency"}, 32'(cyc), 32'(TO));
            model_done(1);
        end else begin
            for (int i = 1; i < d; i++) begin
                tick;
                if (tx_load) loads++;
            end
            tx_done = 1'b1;
            tick;
            tx_done = 1'b0;
            chk({tag, "_no_to_err"}, 32'(timeout_err), 32'd0);
            model_done(0);
        end
        chk({tag, "_no_load_in_wait"}, 32'(loads), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_load"}, 32'(tx_load), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        model_reset();
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        int n, w, loads;
        logic [3:0] r, lk;
        logic [7:0] ed;

        tbl[0]  = '{4'b1111, 4'b0000, 0, 8'hA0};
        tbl[1]  = '{4'b1111, 4'b0000, 1, 8'hB1};
        tbl[2]  = '{4'b1111, 4'b0000, 2, 8'hC2};
        tbl[3]  = '{4'b1111, 4'b0000, 3, 8'hD3};
        tbl[4]  = '{4'b1111, 4'b0000, 0, 8'hA0};
        tbl[5]  = '{4'b1111, 4'b0000, 1, 8'hB1};
        tbl[6]  = '{4'b0001, 4'b0000, 0, 8'hA0};
        tbl[7]  = '{4'b0011, 4'b0010, 1, 8'hB1};
        tbl[8]  = '{4'b0011, 4'b0010, 1, 8'hB1};
        tbl[9]  = '{4'b0011, 4'b0010, 1, 8'hB1};
        tbl[10] = '{4'b0011, 4'b0010, 1, 8'hB1};
        tbl[11] = '{4'b0011, 4'b0010, 0, 8'hA0};

        reset = 1'b1;
        req = '0; req_lock = '0; req_data = '0;
        tx_ready = 1'b0; tx_done = 1'b0;
        model_reset();
        tick;
        tick;
        check_reset_vals("rst");
        reset = 1'b0;
        tx_ready = 1'b1;

        // single request from source 2
        req_data = 32'h0041_0000;
        req = 4'b0100;
        wait_load(20, n);
        chk("t1_latency", 32'(n), 32'd1);
        check_grant("t1", 2, 8'h41);
        model_grant(2, 4'b0000);
        req = '0;
        run_wait("t1", 10, 0, 8'h41);

        // round robin and locked burst table
        do_reset();
        req_data = 32'hD3C2_B1A0;
        foreach (tbl[i]) begin
            req = tbl[i].r;
            req_lock = tbl[i].lk;
            wait_load(20, n);
            check_grant($sformatf("tbl%0d", i), tbl[i].exp_owner,
                        tbl[i].exp_data);
            model_grant(tbl[i].exp_owner, tbl[i].lk);
            run_wait($sformatf("tbl%0d", i), 4, 0, tbl[i].exp_data);
        end
        req = '0;
        req_lock = '0;

        // watchdog recovery
        do_reset();
        req_data = 32'h5544_3322;
        req = 4'b1100;
        wait_load(20, n);
        w = model_pick(4'b1100);
        check_grant("to", w, 8'h44);
        model_grant(w, 4'b0000);
        req = 4'b1000;
        run_wait("to", 0, 1, 8'h44);
        wait_load(5, n);
        chk("to_next_latency", 32'(n), 32'd1);
        chk("to_err_width", 32'(timeout_err), 32'd0);
        w = model_pick(4'b1000);
        check_grant("to_next", w, 8'h55);
        model_grant(w, 4'b0000);
        req = '0;
        run_wait("to_next", 2, 0, 8'h55);

        // stall on tx_ready, then done coincident with watchdog expiry
        tx_ready = 1'b0;
        req = 4'b1000;
        loads = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (tx_load) loads++;
        end
        chk("stall_no_load", 32'(loads), 32'd0);
        tx_ready = 1'b1;
        wait_load(5, n);
        chk("stall_latency", 32'(n), 32'd1);
        w = model_pick(4'b1000);
        check_grant("stall", w, 8'h55);
        model_grant(w, 4'b0000);
        req = '0;
        run_wait("coinc", TO, 0, 8'h55);
        tick;
        chk("coinc_err_late", 32'(timeout_err), 32'd0);

        // reset during WAIT
        req_data = 32'h0000_7766;
        req = 4'b0001;
        wait_load(5, n);
        w = model_pick(4'b0001);
        check_grant("rw", w, 8'h66);
        model_grant(w, 4'b0000);
        req = '0;
        tick;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check_reset_vals("rw_async");
        model_reset();
        tick;
        chk("rw_hold_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        req = 4'b0010;
        wait_load(5, n);
        chk("rw_latency", 32'(n), 32'd1);
        w = model_pick(4'b0010);
        check_grant("rw_after", w, 8'h77);
        model_grant(w, 4'b0000);
        req = '0;
        run_wait("rw_after", 3, 0, 8'h77);

        // randomized transactions against the model
        for (int t = 0; t < 60; t++) begin
            int stall;
            r = 4'($urandom_range(1, 15));
            lk = 4'($urandom_range(0, 15));
            req_data = $urandom;
            stall = $urandom_range(0, 3);
            req = r;
            req_lock = lk;
            tx_ready = (stall == 0);
            loads = 0;
            for (int i = 0; i < stall; i++) begin
                tick;
                if (tx_load) loads++;
            end
            if (stall != 0) chk("rnd_stall", 32'(loads), 32'd0);
            tx_ready = 1'b1;
            wait_load(5, n);
            w = model_pick(r);
            ed = req_data[w*8 +: 8];
            check_grant($sformatf("rnd%0d", t), w, ed);
            model_grant(w, lk);
            req_data = $urandom;
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                run_wait($sformatf("rnd%0d", t), 0, 1, ed);
            else
                run_wait($sformatf("rnd%0d", t),
                         $urandom_range(1, 6), 0, ed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter in system_toplevel among up to four byte sources, e.g. PicoBlaze output port, RX echo path, status reporter and debug dump.
- Round-robin arbitration with an optional per-requester lock, so a multi-byte message is not interleaved with other sources.
- Sequences the transmitter: load one byte, wait for its done pulse, re-arbitrate.
- A watchdog recovers from a transmitter that never reports done.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 in this revision).
- IDX_W, 2, width of the owner index.
- MAX_BURST, 16, maximum consecutive locked bytes before forced rotation (1..255).
- TIMEOUT, 1200000, cycles to wait for tx_done after a load (more than one 11-bit frame at 9600 baud, 100 MHz clk).
- TO_W, 21, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester byte request; held until the matching ack.
- req_lock  in  N_REQ  keep ownership after this byte if the same requester is still requesting.
- req_data  in  8*N_REQ  byte for requester i on bits [8i+7:8i].
- tx_ready  in  1  transmitter idle and able to accept a load.
- tx_done  in  1  one-cycle pulse: current frame's stop bit finished.
- tx_load  out  1  one-cycle load strobe to the transmitter.
- tx_data  out  8  byte presented with tx_load.
- ack  out  N_REQ  one-hot, one-cycle pulse: requester's byte accepted.
- owner  out  IDX_W  index of the last or current granted requester.
- busy  out  1  high in LOAD and WAIT.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values (applied immediately on reset assertion, asynchronous):
  - outputs: tx_load=0, tx_data=0x00, ack=0, owner=0, busy=0, timeout_err=0.
  - internal: state=IDLE, rr pointer=0, burst count=0, lock flag=0, timeout counter=0.
- Reset asserted mid-LOAD or mid-WAIT aborts the transaction silently; no ack and no error pulse.
- States:
  - IDLE → LOAD at the clock edge where tx_ready=1 and |req.
  - LOAD → WAIT always, after exactly one cycle.
  - WAIT → IDLE on tx_done, or on timeout.
- Arbitration, evaluated in IDLE:
  - If the lock flag is set, req[owner]=1 and burst count < MAX_BURST, the winner is owner.
  - Otherwise the winner is the first i with req[i]=1, scanning from rr pointer upward with wrap 3→0.
- At the IDLE→LOAD edge, register:
  - owner = winner;
  - tx_data = req_data[winner] (captured, so later changes to req_data are ignored);
  - lock flag = req_lock[winner];
  - burst count = (same owner and locked) ? count+1 : 1.
- LOAD cycle: tx_load=1 and ack[owner]=1 for exactly this one cycle. Request-to-load latency is 1 cycle after the arbitration edge.
- Leaving WAIT:
  - If unlocked, or burst count reached MAX_BURST: rr pointer = owner+1 mod 4, lock flag cleared.
  - Otherwise rr pointer is unchanged.
- busy=1 in LOAD and WAIT. tx_data holds its value until the next LOAD.
- Watchdog:
  - Counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT-1 without tx_done: timeout_err pulses 1 cycle, FSM returns to IDLE, rotation applies as if unlocked.
- tx_done and timeout in the same cycle: tx_done wins, no timeout_err.
- tx_done outside WAIT is ignored.
- tx_ready=0 in IDLE stalls arbitration indefinitely; requests stay pending.
- A requester that drops req before being granted simply loses eligibility; this is not an error.
- Minimum spacing between tx_load pulses is 3 cycles (LOAD, WAIT of at least 1 cycle, IDLE).

Test Plan:
- Reset, then req=0100 with req_data[23:16]=0x41, tx_ready=1 → one cycle after the arbitration edge: tx_load=1, tx_data=0x41, ack=0100, owner=2, busy=1; no further load until tx_done is pulsed.
- req=1111 held with no locks; pulse tx_done 5 cycles after each load → grant order 0,1,2,3,0,1; each ack is one-hot and one cycle wide.
- MAX_BURST=4, req=0011, req_lock=0010, rr pointer=1 → four consecutive grants to 1, then grant to 0 (pointer moves to 2; 2 and 3 are idle, so the scan wraps to 0).
- TIMEOUT=50, one grant, tx_done never pulsed → timeout_err pulses exactly 50 cycles after entering WAIT, FSM returns to IDLE, next pending requester is granted normally.
- tx_ready=0 for 100 cycles with req=1000 → no tx_load; tx_ready rises → tx_load one cycle after the arbitration edge. tx_done coincident with the timeout cycle → no timeout_err.
- Assert reset during WAIT → all outputs at reset values immediately, no ack or error pulse; after release with req=0010 → owner=1 granted first (pointer was reset to 0, requester 0 idle).
